mod_mul_acc: RTL and testbench

MOD_MUL_ACC -- requirements
Module: mod_mul_acc

---
 rtl/mod_mul_pkg.sv | 11 +
 rtl/mod_mul_acc_if.sv | 23 ++
 rtl/mod_reduce.sv | 49 ++++
 rtl/mod_mul_acc.sv | 110 +++++++++++
 tb/tb_mod_mul_acc.sv | 135 +++++++++++++
 5 files changed

// File: rtl/mod_mul_pkg.sv
// Shared constants for the modular multiply/accumulate block: FSM encoding and default widths.
package mod_mul_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_FRAC_SHIFT = 12;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MUL  = 3'd1;
    localparam logic [2:0] ST_RED  = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_OUT  = 3'd4;
endpackage

// File: rtl/mod_mul_acc_if.sv
// Request/response bundle for mod_mul_acc; slave side is the block, master side the requester.
interface mod_mul_acc_if #(parameter int DATA_WIDTH = mod_mul_pkg::DEF_DATA_WIDTH);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] q;
    logic                  mode;
    logic                  acc_clr;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] result;
    logic                  err;

    modport slave (
        input  in_valid, a, b, q, mode, acc_clr, out_ready,
        output in_ready, out_valid, result, err
    );
    modport master (
        output in_valid, a, b, q, mode, acc_clr, out_ready,
        input  in_ready, out_valid, result, err
    );
endinterface

// File: rtl/mod_reduce.sv
// Restoring shift-subtract remainder: one dividend bit per cycle, DATA_WIDTH cycles after start.
// done is high during the cycle whose closing edge produces the final remainder.
module mod_reduce #(
    parameter int DATA_WIDTH = mod_mul_pkg::DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] r0,
    output logic                  done
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic [DATA_WIDTH-1:0] dvd;
    logic [DATA_WIDTH-1:0] dsr;
    logic [DATA_WIDTH-1:0] rem;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH:0]   rem_sh;
    logic [DATA_WIDTH:0]   diff;

    // rem < divisor < 2^(DATA_WIDTH-1), so the shifted remainder fits in one extra bit
    always_comb begin
        rem_sh = {rem, dvd[DATA_WIDTH-1]};
        diff   = rem_sh - {1'b0, dsr};
    end

    assign done = (cnt == CW'(1));
    assign r0   = rem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvd <= '0;
            dsr <= '0;
            rem <= '0;
            cnt <= '0;
        end else if (start) begin
            dvd <= dividend;
            dsr <= divisor;
            rem <= '0;
            cnt <= CW'(DATA_WIDTH);
        end else if (cnt != '0) begin
            dvd <= {dvd[DATA_WIDTH-2:0], 1'b0};
            rem <= diff[DATA_WIDTH] ? rem_sh[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
            cnt <= cnt - CW'(1);
        end
    end
endmodule

// File: rtl/mod_mul_acc.sv
// Fixed-point signed multiply, reduce mod q, optional accumulate; one transaction in flight.
// Latency DATA_WIDTH+3 edges (accept edge included), 1 edge for q <= 0; result held until out_ready.
module mod_mul_acc
    import mod_mul_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAC_SHIFT = DEF_FRAC_SHIFT
) (
    input  logic         clk,
    input  logic         rst,
    mod_mul_acc_if.slave bus
);
    logic [2:0]              state;
    logic [DATA_WIDTH-1:0]   a_r, b_r, q_r;
    logic                    mode_r, clr_r, m_neg;
    logic [DATA_WIDTH-1:0]   acc, q_acc;
    logic [DATA_WIDTH-1:0]   res;
    logic                    err_r;
    logic [2*DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0]   m, m_abs;
    logic [DATA_WIDTH-1:0]   r0, r_fix, base;
    logic [DATA_WIDTH:0]     sum, sum_red;
    logic                    red_done;
    logic                    q_pos;

    // Sign-extended operands make the low 2*DATA_WIDTH bits the true signed product
    always_comb begin
        prod  = {{DATA_WIDTH{a_r[DATA_WIDTH-1]}}, a_r} * {{DATA_WIDTH{b_r[DATA_WIDTH-1]}}, b_r};
        m     = prod[FRAC_SHIFT+DATA_WIDTH-1:FRAC_SHIFT];
        m_abs = m[DATA_WIDTH-1] ? (~m + 1'b1) : m;
    end

    mod_reduce #(.DATA_WIDTH(DATA_WIDTH)) u_reduce (
        .clk      (clk),
        .rst      (rst),
        .start    (state == ST_MUL),
        .dividend (m_abs),
        .divisor  (q_r),
        .r0       (r0),
        .done     (red_done)
    );

    always_comb begin
        r_fix   = (m_neg && (r0 != '0)) ? (q_r - r0) : r0;
        base    = (clr_r || (q_r != q_acc)) ? '0 : acc;
        sum     = {1'b0, base} + {1'b0, r_fix};
        sum_red = (sum >= {1'b0, q_r}) ? (sum - {1'b0, q_r}) : sum;
        q_pos   = !bus.q[DATA_WIDTH-1] && (bus.q != '0);
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_OUT);
    assign bus.result    = res;
    assign bus.err       = err_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            a_r    <= '0;
            b_r    <= '0;
            q_r    <= '0;
            mode_r <= 1'b0;
            clr_r  <= 1'b0;
            m_neg  <= 1'b0;
            acc    <= '0;
            q_acc  <= '0;
            res    <= '0;
            err_r  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (bus.in_valid) begin
                    a_r    <= bus.a;
                    b_r    <= bus.b;
                    q_r    <= bus.q;
                    mode_r <= bus.mode;
                    clr_r  <= bus.acc_clr;
                    if (q_pos) begin
                        state <= ST_MUL;
                    end else begin
                        res   <= '0;
                        err_r <= 1'b1;
                        state <= ST_OUT;
                    end
                end
                ST_MUL: begin
                    m_neg <= m[DATA_WIDTH-1];
                    state <= ST_RED;
                end
                ST_RED: if (red_done) state <= ST_FIX;
                ST_FIX: begin
                    err_r <= 1'b0;
                    if (mode_r) begin
                        acc   <= sum_red[DATA_WIDTH-1:0];
                        q_acc <= q_r;
                        res   <= sum_red[DATA_WIDTH-1:0];
                    end else begin
                        res   <= r_fix;
                    end
                    state <= ST_OUT;
                end
                ST_OUT: if (bus.out_ready) begin
                    res   <= '0;
                    err_r <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mod_mul_acc.sv
// Directed vectors with a result scoreboard; the driver checks latency/hold, the monitor checks values.
module tb_mod_mul_acc;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic seen;
    logic [32:0] exp_q[$];

    mod_mul_acc_if #(.DATA_WIDTH(32)) bus ();

    mod_mul_acc #(.DATA_WIDTH(32), .FRAC_SHIFT(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Monitor: one scoreboard pop per rising out_valid
    always @(negedge clk) begin
        if (!bus.out_valid) begin
            seen <= 1'b0;
        end else if (!seen) begin
            seen <= 1'b1;
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 64'd1, 64'd0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("result", {32'd0, bus.result}, {32'd0, e[31:0]});
                chk("err", {63'd0, bus.err}, {63'd0, e[32]});
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                        input logic mode, input logic clr, input logic [31:0] exp_res,
                        input logic exp_err, input int exp_lat, input int hold, input logic early);
        int n;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_before_accept", {63'd0, bus.in_ready}, 64'd1);
        bus.a = a; bus.b = b; bus.q = q; bus.mode = mode; bus.acc_clr = clr;
        bus.in_valid  = 1'b1;
        bus.out_ready = early;
        exp_q.push_back({exp_err, exp_res});
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 64'(n), 64'(exp_lat));
        bus.out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.a = 32'd7; bus.q = 32'd3;
            @(posedge clk); #1;
            chk("hold_result", {32'd0, bus.result}, {32'd0, exp_res});
            chk("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("released_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("released_result", {32'd0, bus.result}, 64'd0);
    endtask

    initial begin
        total = 0; bad = 0; seen = 1'b0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.q = '0;
        bus.mode = 1'b0; bus.acc_clr = 1'b0; bus.out_ready = 1'b0;
        rst = 1'b0;
        #12;
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_result", {32'd0, bus.result}, 64'd0);
        chk("rst_err", {63'd0, bus.err}, 64'd0);
        rst = 1'b1;

        //    a              b         q            md    clr   result    err   lat hold early
        send(32'd12288,     32'd4096, 32'd1000,    1'b0, 1'b0, 32'd288,  1'b0, 35, 0, 1'b0);
        send(-32'sd12288,   32'd4096, 32'd1000,    1'b0, 1'b0, 32'd712,  1'b0, 35, 0, 1'b0);
        send(-32'sd1,       32'd1,    32'd7,       1'b0, 1'b0, 32'd6,    1'b0, 35, 0, 1'b0);
        send(32'd1,         32'd1,    32'd1,       1'b0, 1'b0, 32'd0,    1'b0, 35, 0, 1'b0);
        send(32'd12288,     32'd4096, 32'd1000,    1'b1, 1'b1, 32'd288,  1'b0, 35, 0, 1'b0);
        send(32'd12288,     32'd4096, 32'd1000,    1'b1, 1'b0, 32'd576,  1'b0, 35, 0, 1'b0);
        send(32'd12288,     32'd4096, 32'd1000,    1'b1, 1'b0, 32'd864,  1'b0, 35, 0, 1'b0);
        send(32'd12288,     32'd4096, 32'd1000,    1'b1, 1'b0, 32'd152,  1'b0, 35, 0, 1'b0);
        send(32'd5,         32'd9,    32'd0,       1'b1, 1'b0, 32'd0,    1'b1, 1,  0, 1'b0);
        send(32'd12288,     32'd4096, 32'd1000,    1'b1, 1'b0, 32'd440,  1'b0, 35, 5, 1'b0);
        send(32'd12288,     32'd4096, -32'sd5,     1'b0, 1'b0, 32'd0,    1'b1, 1,  0, 1'b0);
        send(32'd12288,     32'd4096, 32'd1000,    1'b0, 1'b0, 32'd288,  1'b0, 35, 0, 1'b0);
        send(32'd12288,     32'd4096, 32'd1000,    1'b1, 1'b0, 32'd728,  1'b0, 35, 0, 1'b0);
        send(32'd12288,     32'd4096, 32'd999,     1'b1, 1'b0, 32'd300,  1'b0, 35, 0, 1'b0);
        send(32'd12288,     32'd4096, 32'd1000,    1'b1, 1'b0, 32'd288,  1'b0, 35, 0, 1'b0);

        // Abort a mode-1 transaction mid-reduction; accumulator must restart from zero
        bus.a = 32'd12288; bus.b = 32'd4096; bus.q = 32'd1000;
        bus.mode = 1'b1; bus.acc_clr = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midred_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("midred_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("midred_result", {32'd0, bus.result}, 64'd0);
        chk("midred_err", {63'd0, bus.err}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        send(32'd12288,     32'd4096, 32'd1000,    1'b1, 1'b0, 32'd288,  1'b0, 35, 0, 1'b0);
        send(32'd12288,     32'd4096, 32'd1000,    1'b0, 1'b0, 32'd288,  1'b0, 35, 0, 1'b1);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
